// File: rtl/uart_csr_multi_pkg.sv
// Shared register-map constants for the multi-channel UART CSR block.
package uart_csr_pkg;

    localparam logic [15:0] OFS_CR    = 16'h0000;
    localparam logic [15:0] OFS_ISR   = 16'h0004;
    localparam logic [15:0] OFS_IER   = 16'h0008;
    localparam logic [15:0] OFS_PE    = 16'h000C;
    localparam logic [15:0] OFS_FE    = 16'h0010;
    localparam logic [15:0] OFS_NE    = 16'h0014;
    localparam logic [15:0] OFS_CLR   = 16'h0018;
    localparam logic [15:0] OFS_ID    = 16'h0F00;
    localparam logic [15:0] CH_STRIDE = 16'h0040;

    localparam int ISR_PE = 0;
    localparam int ISR_FE = 1;
    localparam int ISR_NE = 2;

    localparam logic [31:0] CR_WMASK = 32'h0000_0F3F;

endpackage

// File: rtl/uart_csr_multi_if.sv
// Peripheral bus bundle between the bus decoder (master) and the CSR block (slave).
interface uart_csr_multi_if;

    logic [31:0] peripheral_data_in;
    logic [31:0] peripheral_addr_in;
    logic        peripheral_read_en;
    logic        peripheral_write_en;
    logic [31:0] peripheral_base_addr;
    logic [31:0] peripheral_data_out;
    logic        peripheral_data_out_en;

    modport master (
        output peripheral_data_in, peripheral_addr_in, peripheral_read_en,
               peripheral_write_en, peripheral_base_addr,
        input  peripheral_data_out, peripheral_data_out_en
    );

    modport slave (
        input  peripheral_data_in, peripheral_addr_in, peripheral_read_en,
               peripheral_write_en, peripheral_base_addr,
        output peripheral_data_out, peripheral_data_out_en
    );

endinterface

// File: rtl/uart_csr_multi_chan.sv
// One UART channel's registers: control word, error counters, sticky ISR, IER and irq term.
module uart_csr_chan
    import uart_csr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [5:0]       ofs_i,
    input  logic [31:0]      wdata_i,
    input  logic             pe_i,
    input  logic             fe_i,
    input  logic             ne_i,
    output logic [31:0]      cr_o,
    output logic [2:0]       isr_o,
    output logic [2:0]       ier_o,
    output logic [CNT_W-1:0] pe_cnt_o,
    output logic [CNT_W-1:0] fe_cnt_o,
    output logic [CNT_W-1:0] ne_cnt_o,
    output logic             irq_o
);

    logic [31:0]      cr_q, cr_d;
    logic [2:0]       isr_q, isr_d;
    logic [2:0]       ier_q, ier_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       flag, clr, w1c;

    // Clear beats increment; the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clear);
        if (clear)
            return '0;
        if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_W'(1'b1);
        return cnt;
    endfunction

    always_comb begin
        flag         = '0;
        flag[ISR_PE] = pe_i;
        flag[ISR_FE] = fe_i;
        flag[ISR_NE] = ne_i;
    end

    always_comb begin
        cr_d  = cr_q;
        ier_d = ier_q;
        clr   = '0;
        w1c   = '0;
        if (wr_i) begin
            case (ofs_i)
                OFS_CR[5:0]:  cr_d  = wdata_i & CR_WMASK;
                OFS_ISR[5:0]: w1c   = wdata_i[2:0];
                OFS_IER[5:0]: ier_d = wdata_i[2:0];
                OFS_CLR[5:0]: clr   = wdata_i[2:0];
                default: ;
            endcase
        end
        // A new event in the same cycle as its W1C keeps the bit pending.
        isr_d = (isr_q & ~w1c) | flag;
        for (int k = 0; k < 3; k++)
            cnt_d[k] = cnt_next(cnt_q[k], flag[k], clr[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_q  <= '0;
            isr_q <= '0;
            ier_q <= '0;
            for (int k = 0; k < 3; k++)
                cnt_q[k] <= '0;
        end else begin
            cr_q  <= cr_d;
            isr_q <= isr_d;
            ier_q <= ier_d;
            for (int k = 0; k < 3; k++)
                cnt_q[k] <= cnt_d[k];
        end
    end

    assign cr_o     = cr_q;
    assign isr_o    = isr_q;
    assign ier_o    = ier_q;
    assign pe_cnt_o = cnt_q[ISR_PE];
    assign fe_cnt_o = cnt_q[ISR_FE];
    assign ne_cnt_o = cnt_q[ISR_NE];
    assign irq_o    = |(isr_q & ier_q);

endmodule

// File: rtl/uart_csr_multi.sv
// Multi-channel UART CSR block: bus decode, per-channel register instances, read mux and irq.
module uart_csr_multi
    import uart_csr_pkg::*;
#(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 16,
    parameter logic [7:0]  VERSION = 8'h02
) (
    input  logic                  clk_125,
    input  logic                  rst_n_125,
    uart_csr_multi_if.slave       bus,
    input  logic [NUM_CH-1:0]     pe_flag,
    input  logic [NUM_CH-1:0]     fe_flag,
    input  logic [NUM_CH-1:0]     ne_flag,
    output logic [32*NUM_CH-1:0]  axi_uart_cr,
    output logic                  uart_irq
);

    localparam logic [31:0] ID_VAL = {8'h00, VERSION, 8'(NUM_CH), 8'(CNT_W)};

    logic             sel, rd_fire, wr_fire;
    logic [15:0]      ofs;
    logic [9:0]       ch_idx;
    logic [31:0]      rd_data;
    logic             unused_base;

    logic [NUM_CH-1:0] ch_wr, ch_irq;
    logic [31:0]       ch_cr  [NUM_CH];
    logic [2:0]        ch_isr [NUM_CH];
    logic [2:0]        ch_ier [NUM_CH];
    logic [CNT_W-1:0]  ch_pe  [NUM_CH];
    logic [CNT_W-1:0]  ch_fe  [NUM_CH];
    logic [CNT_W-1:0]  ch_ne  [NUM_CH];

    logic [31:0] data_out_q, data_out_d;
    logic        data_out_en_q, data_out_en_d;
    logic        irq_q, irq_d;

    assign sel         = (bus.peripheral_addr_in[31:16] == bus.peripheral_base_addr[15:0]);
    assign unused_base = ^bus.peripheral_base_addr[31:16];
    assign rd_fire     = bus.peripheral_read_en  && sel;
    assign wr_fire     = bus.peripheral_write_en && sel;
    assign ofs         = bus.peripheral_addr_in[15:0];
    assign ch_idx      = ofs[15:6];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_wr[c] = wr_fire && (ch_idx == 10'(c));

        uart_csr_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (clk_125),
            .rst_n    (rst_n_125),
            .wr_i     (ch_wr[c]),
            .ofs_i    (ofs[5:0]),
            .wdata_i  (bus.peripheral_data_in),
            .pe_i     (pe_flag[c]),
            .fe_i     (fe_flag[c]),
            .ne_i     (ne_flag[c]),
            .cr_o     (ch_cr[c]),
            .isr_o    (ch_isr[c]),
            .ier_o    (ch_ier[c]),
            .pe_cnt_o (ch_pe[c]),
            .fe_cnt_o (ch_fe[c]),
            .ne_cnt_o (ch_ne[c]),
            .irq_o    (ch_irq[c])
        );

        assign axi_uart_cr[32*c +: 32] = ch_cr[c];
    end

    // Reads sample register state before this cycle's write lands.
    always_comb begin
        rd_data = '0;
        if (ofs == OFS_ID) begin
            rd_data = ID_VAL;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 10'(c)) begin
                    case (ofs[5:0])
                        OFS_CR[5:0]:  rd_data = ch_cr[c];
                        OFS_ISR[5:0]: rd_data = {29'b0, ch_isr[c]};
                        OFS_IER[5:0]: rd_data = {29'b0, ch_ier[c]};
                        OFS_PE[5:0]:  rd_data = 32'(ch_pe[c]);
                        OFS_FE[5:0]:  rd_data = 32'(ch_fe[c]);
                        OFS_NE[5:0]:  rd_data = 32'(ch_ne[c]);
                        default:      rd_data = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        data_out_d    = rd_fire ? rd_data : data_out_q;
        data_out_en_d = rd_fire;
        irq_d         = |ch_irq;
    end

    always_ff @(posedge clk_125 or negedge rst_n_125) begin
        if (!rst_n_125) begin
            data_out_q    <= '0;
            data_out_en_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            irq_q         <= irq_d;
        end
    end

    assign bus.peripheral_data_out    = data_out_q;
    assign bus.peripheral_data_out_en = data_out_en_q;
    assign uart_irq                   = irq_q;

endmodule

// File: tb/tb_uart_csr_multi.sv
// Scoreboard bench for uart_csr_multi: expected read data queued at issue, compared on data_out_en.
module tb_uart_csr_multi;

    localparam int          NCH  = 4;
    localparam int          CW   = 4;
    localparam logic [31:0] BASE = 32'h0000_ABCD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    logic [NCH-1:0]     pe, fe, ne;
    logic [NCH-1:0]     zero_flags;
    logic [32*NCH-1:0]  cr, cr16;
    logic               irq, irq16;

    uart_csr_multi_if bus();
    uart_csr_multi_if bus16();

    uart_csr_multi #(.NUM_CH(NCH), .CNT_W(CW), .VERSION(8'h02)) dut (
        .clk_125(clk), .rst_n_125(rst_n), .bus(bus.slave),
        .pe_flag(pe), .fe_flag(fe), .ne_flag(ne),
        .axi_uart_cr(cr), .uart_irq(irq)
    );

    uart_csr_multi #(.NUM_CH(NCH), .CNT_W(16), .VERSION(8'h02)) dut16 (
        .clk_125(clk), .rst_n_125(rst_n), .bus(bus16.slave),
        .pe_flag(zero_flags), .fe_flag(zero_flags), .ne_flag(zero_flags),
        .axi_uart_cr(cr16), .uart_irq(irq16)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every data_out_en pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.peripheral_data_out_en === 1'b1) begin
            if (exp_q.size() == 0)
                chk_eq("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            else
                chk_eq("rd_data", bus.peripheral_data_out, exp_q.pop_front());
        end
    end

    // All tasks start and end on a falling edge.
    task automatic rd(input logic [15:0] ofs, input logic [31:0] exp);
        bus.peripheral_addr_in = {BASE[15:0], ofs};
        bus.peripheral_read_en = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.peripheral_read_en = 1'b0;
        chk_eq("rd_en_lat", 32'(bus.peripheral_data_out_en), 32'd1);
        @(negedge clk);
        chk_eq("rd_en_pulse", 32'(bus.peripheral_data_out_en), 32'd0);
    endtask

    task automatic wr(input logic [15:0] ofs, input logic [31:0] data);
        bus.peripheral_addr_in  = {BASE[15:0], ofs};
        bus.peripheral_data_in  = data;
        bus.peripheral_write_en = 1'b1;
        @(negedge clk);
        bus.peripheral_write_en = 1'b0;
    endtask

    task automatic chk_cr(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        chk_eq({tag, "_ch0"}, cr[31:0],   e0);
        chk_eq({tag, "_ch1"}, cr[63:32],  e1);
        chk_eq({tag, "_ch2"}, cr[95:64],  e2);
        chk_eq({tag, "_ch3"}, cr[127:96], e3);
    endtask

    initial begin
        pe = '0; fe = '0; ne = '0; zero_flags = '0;
        bus.peripheral_data_in     = '0;
        bus.peripheral_addr_in     = '0;
        bus.peripheral_read_en     = 1'b0;
        bus.peripheral_write_en    = 1'b0;
        bus.peripheral_base_addr   = BASE;
        bus16.peripheral_data_in   = '0;
        bus16.peripheral_addr_in   = '0;
        bus16.peripheral_read_en   = 1'b0;
        bus16.peripheral_write_en  = 1'b0;
        bus16.peripheral_base_addr = BASE;

        repeat (2) @(negedge clk);
        chk_eq("rst_data_out", bus.peripheral_data_out, 32'h0);
        chk_eq("rst_data_en", 32'(bus.peripheral_data_out_en), 32'd0);
        chk_eq("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_cr("rst_cr", 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset-state reads and ID words
        rd(16'h0000, 32'h0);
        rd(16'h0F00, 32'h0002_0404);
        bus16.peripheral_addr_in = {BASE[15:0], 16'h0F00};
        bus16.peripheral_read_en = 1'b1;
        @(negedge clk);
        bus16.peripheral_read_en = 1'b0;
        chk_eq("id16_en", 32'(bus16.peripheral_data_out_en), 32'd1);
        chk_eq("id16_data", bus16.peripheral_data_out, 32'h0002_0410);

        // Control register write mask
        wr(16'h0040, 32'hFFFF_FFFF);
        chk_cr("cr_wr", 32'h0, 32'h0000_0F3F, 32'h0, 32'h0);
        rd(16'h0040, 32'h0000_0F3F);
        rd(16'h0000, 32'h0);

        // Counter increment and saturation on ch2
        for (int i = 0; i < 5; i++) begin
            pe[2] = 1'b1;
            @(negedge clk);
        end
        pe[2] = 1'b0;
        rd(16'h008C, 32'd5);
        for (int i = 0; i < 15; i++) begin
            pe[2] = 1'b1;
            @(negedge clk);
        end
        pe[2] = 1'b0;
        rd(16'h008C, 32'd15);
        rd(16'h0090, 32'd0);
        rd(16'h0084, 32'h1);
        chk_eq("irq_masked", 32'(irq), 32'd0);
        pe[2] = 1'b1;
        wr(16'h0098, 32'h1);
        pe[2] = 1'b0;
        rd(16'h008C, 32'd0);
        rd(16'h0098, 32'd0);

        // Interrupt path on ch0
        wr(16'h0008, 32'h2);
        rd(16'h0008, 32'h2);
        fe[0] = 1'b1;
        @(negedge clk);
        fe[0] = 1'b0;
        chk_eq("irq_lat0", 32'(irq), 32'd0);
        @(negedge clk);
        chk_eq("irq_set", 32'(irq), 32'd1);
        rd(16'h0004, 32'h2);
        rd(16'h0010, 32'd1);
        wr(16'h0004, 32'h2);
        @(negedge clk);
        chk_eq("irq_clr", 32'(irq), 32'd0);
        rd(16'h0004, 32'h0);
        fe[0] = 1'b1;
        wr(16'h0004, 32'h2);
        fe[0] = 1'b0;
        rd(16'h0004, 32'h2);
        chk_eq("irq_reset", 32'(irq), 32'd1);

        // Foreign block select: no effect, no response
        bus.peripheral_addr_in  = 32'h1234_0040;
        bus.peripheral_data_in  = 32'h0;
        bus.peripheral_write_en = 1'b1;
        bus.peripheral_read_en  = 1'b1;
        @(negedge clk);
        bus.peripheral_write_en = 1'b0;
        bus.peripheral_read_en  = 1'b0;
        chk_eq("nosel_en", 32'(bus.peripheral_data_out_en), 32'd0);
        chk_cr("nosel_cr", 32'h0, 32'h0000_0F3F, 32'h0, 32'h0);
        rd(16'h0200, 32'h0);
        rd(16'h001C, 32'h0);

        // Same-cycle read and write returns the old value
        bus.peripheral_addr_in  = {BASE[15:0], 16'h00C0};
        bus.peripheral_data_in  = 32'h0000_0105;
        bus.peripheral_write_en = 1'b1;
        bus.peripheral_read_en  = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        bus.peripheral_write_en = 1'b0;
        bus.peripheral_read_en  = 1'b0;
        chk_eq("rw_en", 32'(bus.peripheral_data_out_en), 32'd1);
        @(negedge clk);
        rd(16'h00C0, 32'h0000_0105);

        // Asynchronous reset in the middle of a read
        bus.peripheral_addr_in = {BASE[15:0], 16'h0040};
        bus.peripheral_read_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_data_out", bus.peripheral_data_out, 32'h0);
        chk_eq("arst_en", 32'(bus.peripheral_data_out_en), 32'd0);
        chk_eq("arst_irq", 32'(irq), 32'd0);
        chk_cr("arst_cr", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        bus.peripheral_read_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("arst_no_rsp", 32'(bus.peripheral_data_out_en), 32'd0);
        end
        rd(16'h0040, 32'h0);
        rd(16'h0004, 32'h0);

        chk_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_csr_multi.md
Name: uart_csr_multi

Overview:
- Parametrised control/status register block for NUM_CH UART channels on the peripheral bus.
- Per channel it provides:
  - a control register;
  - saturating parity/framing/noise error counters with write-to-clear;
  - sticky W1C interrupt status, interrupt enable and an aggregated interrupt output.
- Sits between the peripheral bus decoder and the UART RX/TX channel cores.

Parameters:
- NUM_CH, 4, number of UART channels (1..16).
- CNT_W, 16, error counter width in bits (1..32); read values are zero-extended to 32.
- VERSION, 8'h02, version byte returned in the ID register.

Ports:
- clk_125  input  1  system clock.
- rst_n_125  input  1  reset; asynchronous assert, active-low.
- pe_flag  input  NUM_CH  per-channel parity-error pulse, 1 cycle per event.
- fe_flag  input  NUM_CH  per-channel framing-error pulse.
- ne_flag  input  NUM_CH  per-channel noise-error pulse.
- axi_uart_cr  output  32*NUM_CH  per-channel control word; channel c occupies bits [32c+31:32c].
- peripheral_data_in  input  32  write data.
- peripheral_addr_in  input  32  address; [31:16] block select, [15:0] offset.
- peripheral_read_en  input  1  read strobe, 1 cycle.
- peripheral_write_en  input  1  write strobe, 1 cycle.
- peripheral_base_addr  input  32  block base; only [15:0] is compared with addr[31:16].
- peripheral_data_out  output  32  read data.
- peripheral_data_out_en  output  1  read-data valid pulse.
- uart_irq  output  1  registered OR of all enabled pending interrupts.

Behaviour:
- Block select: sel = (addr[31:16] == base[15:0]). Strobes with sel=0 have no effect and produce no response.
- Channel c owns offsets c*0x40 .. c*0x40+0x3C. Per-channel register map:
  - 0x00 CR: RW. Only bits [11:8] and [5:0] are writable; all other bits read 0.
  - 0x04 ISR: bit0 PE, bit1 FE, bit2 NE. Sticky; set by the flag; write-1-to-clear.
  - 0x08 IER: RW bits [2:0].
  - 0x0C PE count: RO.
  - 0x10 FE count: RO.
  - 0x14 NE count: RO.
  - 0x18 CNT_CLR: write-only, reads 0. Data bits [2:0] clear the PE/FE/NE counters.
- Global offset 0x0F00 ID: RO, value {8'h0, VERSION, NUM_CH[7:0], CNT_W[7:0]}.
- Unmapped offsets (including channel index >= NUM_CH) behave identically: reads return 0 with data_out_en=1; writes are ignored.
- Reads:
  - 1-cycle latency: data_out and data_out_en are registered on the cycle after read_en.
  - data_out_en is a 1-cycle pulse.
  - data_out holds its last value when no read is in progress.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Counters:
  - Increment by 1 on a flag pulse; saturate at 2^CNT_W-1 with no wrap.
  - Clear and increment in the same cycle: clear wins, result 0.
- ISR: a flag set and a W1C of the same bit in the same cycle leaves the bit set (set wins).
- uart_irq is registered, asserting 1 cycle after OR over c of |(ISR_c & IER_c) becomes true.
- Reset values:
  - all CR, ISR, IER and counters: 0;
  - peripheral_data_out: 0; peripheral_data_out_en: 0; uart_irq: 0.
- Reset assertion mid-transaction aborts the transaction immediately; no response pulse is issued after release.
- Flag inputs are synchronous to clk_125; no synchronisers.

Decomposition:
- Package uart_csr_pkg holds:
  - offset constants: OFS_CR, OFS_ISR, OFS_IER, OFS_PE, OFS_FE, OFS_NE, OFS_CLR, OFS_ID, CH_STRIDE=0x40;
  - ISR bit indices;
  - CR writable mask 32'h0000_0F3F.
- Sub-module uart_csr_chan, instantiated NUM_CH times, holds the per-channel CR, counters, ISR, IER and irq term. It receives the decoded per-channel write strobe, offset and data.
- The top level performs address decode, read mux, output registers and the irq OR.

Test Plan:
- Reset, then read 0x0000, 0x0F00 (NUM_CH=4, CNT_W=16) -> data 0, then 32'h0002_0410, each with data_out_en one cycle after read_en.
- Write 32'hFFFF_FFFF to ch1 CR (0x0040) -> axi_uart_cr[63:32]=32'h0000_0F3F; readback matches; other channels remain 0.
- With CNT_W=4, 20 pe_flag pulses on ch2 -> PE count reads 15 (saturated). Write CNT_CLR=1 in the same cycle as a pe_flag pulse -> count reads 0.
- ch0 IER=3'b010, fe_flag pulse -> ISR=3'b010 and uart_irq=1 one cycle later. W1C 3'b010 -> ISR=0, uart_irq=0. W1C coincident with fe_flag -> bit stays 1.
- Write/read with addr[31:16] != base[15:0] -> no register change, no data_out_en. Read 0x0200 (channel 8) -> data 0, data_out_en=1.
- Assert rst_n_125 low mid-read and between clock edges -> all outputs 0 immediately and no data_out_en pulse after release.
